// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shift register with load handshake
// A new word may be taken on the last-bit edge so consecutive frames stream with no gap.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next, shreg_shifted;
  logic [CW-1:0]    cnt, cnt_next;
  logic             take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  assign last       = (state == SHIFT) && (cnt == CNT_LAST);
  assign load_ready = reset && ((state == IDLE) || last);
  assign take       = load_valid && load_ready;

  // Move the register toward whichever end feeds dout; the vacated end fills with 0.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    dout       = IDLE_LEVEL;
    dout_valid = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          state_next = SHIFT;
          shreg_next = din;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        dout_valid = 1'b1;
        dout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        if (take) begin
          shreg_next = din;
          cnt_next   = '0;
        end else if (last) begin
          state_next = IDLE;
          shreg_next = shreg_shifted;
          cnt_next   = '0;
        end else begin
          shreg_next = shreg_shifted;
          cnt_next   = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for two piso_serializer configurations
// Accepted words are expanded into expected bit streams; a negedge monitor checks every cycle.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din_a = '0;
  logic [7:0] din_b = '0;
  logic       lv_a = 1'b0, lv_b = 1'b0;
  logic       rdy_a, dout_a, dv_a, last_a;
  logic       rdy_b, dout_b, dv_b, last_b;

  logic [1:0] qa[$];
  logic [1:0] qb[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .din(din_a), .load_valid(lv_a), .load_ready(rdy_a),
    .dout(dout_a), .dout_valid(dv_a), .last(last_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .load_valid(lv_b), .load_ready(rdy_b),
    .dout(dout_b), .dout_valid(dv_b), .last(last_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted word becomes WIDTH {last,bit} entries, sent in order.
  task automatic send_a(input logic [3:0] w);
    logic acc;
    bit   done = 0;
    din_a = w;
    lv_a  = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      acc = rdy_a;
      @(posedge clk);
      if (acc) begin
        for (int i = 0; i < 4; i++) qa.push_back({i == 3, w[3-i]});
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("a_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_b(input logic [7:0] w);
    logic acc;
    bit   done = 0;
    din_b = w;
    lv_b  = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      acc = rdy_b;
      @(posedge clk);
      if (acc) begin
        for (int i = 0; i < 8; i++) qb.push_back({i == 7, w[i]});
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("b_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_a(input int n);
    lv_a = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_b(input int n);
    lv_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      check("a_rst_ready", 32'(rdy_a), 32'd0);
      check("a_rst_valid", 32'(dv_a), 32'd0);
      check("a_rst_dout", 32'(dout_a), 32'd0);
      check("a_rst_last", 32'(last_a), 32'd0);
      check("b_rst_ready", 32'(rdy_b), 32'd0);
      check("b_rst_valid", 32'(dv_b), 32'd0);
      check("b_rst_dout", 32'(dout_b), 32'd1);
    end else begin
      check("a_ready", 32'(rdy_a), 32'(qa.size() <= 1));
      check("a_valid", 32'(dv_a), 32'(qa.size() != 0));
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_dout", 32'(dout_a), 32'(e[0]));
        check("a_last", 32'(last_a), 32'(e[1]));
      end else begin
        check("a_idle_dout", 32'(dout_a), 32'd0);
        check("a_idle_last", 32'(last_a), 32'd0);
      end
      check("b_ready", 32'(rdy_b), 32'(qb.size() <= 1));
      check("b_valid", 32'(dv_b), 32'(qb.size() != 0));
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_dout", 32'(dout_b), 32'(e[0]));
        check("b_last", 32'(last_b), 32'(e[1]));
      end else begin
        check("b_idle_dout", 32'(dout_b), 32'd1);
        check("b_idle_last", 32'(last_b), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    #1;
    reset = 1'b0;
    lv_a  = 1'b1;
    lv_b  = 1'b1;
    din_a = 4'hF;
    din_b = 8'hFF;
    repeat (2) @(negedge clk);
    lv_a  = 1'b0;
    lv_b  = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    fork
      begin
        send_a(4'b1011);
        send_a(4'b0110);
        idle_a(3);
        repeat (30) begin
          send_a(4'($urandom));
          if ($urandom_range(0, 2) != 0) idle_a($urandom_range(1, 4));
        end
        idle_a(6);
      end
      begin
        send_b(8'hA5);
        idle_b(2);
        repeat (15) begin
          send_b(8'($urandom));
          if ($urandom_range(0, 1) != 0) idle_b($urandom_range(1, 9));
        end
        idle_b(10);
      end
    join

    // Abort a frame after its second bit, then make sure the next word is clean.
    send_a(4'b1111);
    lv_a = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    check("abort_dout", 32'(dout_a), 32'd0);
    check("abort_valid", 32'(dv_a), 32'd0);
    check("abort_last", 32'(last_a), 32'd0);
    check("abort_ready", 32'(rdy_a), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_a(4'b0001);
    idle_a(6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
